// File: rtl/change_dispenser.sv
// Coin-return unit: dispenses change from Rs10/Rs5 hoppers one acknowledged coin at a time.
// Optional ack timeout with jam pulse, enabled by defining CHANGE_DISP_TIMEOUT_EN.
module change_dispenser #(
  parameter int INV_W   = 8,
  parameter int INIT_5  = 20,
  parameter int INIT_10 = 20,
  parameter int TIMEOUT = 15
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req,
  input  logic [2:0]       change,
  input  logic             coin_ack,
  input  logic             load_5,
  input  logic             load_10,
  input  logic [INV_W-1:0] load_qty,
  output logic             busy,
  output logic             eject_5,
  output logic             eject_10,
  output logic             done,
  output logic             short_err,
  output logic             code_err,
  output logic             jam,
  output logic [INV_W-1:0] cnt_5,
  output logic [INV_W-1:0] cnt_10
);

  typedef enum logic [2:0] {IDLE, CHECK, EJECT, WAIT_ACK, DONE_S} state_t;

  state_t     state;
  logic [2:0] rem;
  logic       coin10;
  logic [2:0] half;
  logic [2:0] n10;
  logic [2:0] need5;
  logic       short_now;

  if (TIMEOUT < 1) begin : g_bad_timeout
    $error("TIMEOUT must be at least 1");
  end

  function automatic logic [INV_W-1:0] sat_add(input logic [INV_W-1:0] a,
                                                input logic [INV_W-1:0] b);
    logic [INV_W:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[INV_W] ? '1 : s[INV_W-1:0];
  endfunction

  // Coverage check: take as many Rs10 coins as possible, the rest must come from Rs5.
  always_comb begin
    half      = {1'b0, rem[2:1]};
    n10       = (INV_W'(half) <= cnt_10) ? half : cnt_10[2:0];
    need5     = rem - {n10[1:0], 1'b0};
    short_now = INV_W'(need5) > cnt_5;
  end

`ifdef CHANGE_DISP_TIMEOUT_EN
  localparam int TMR_W = $clog2(TIMEOUT + 1);
  logic [TMR_W-1:0] tmr;
`else
  assign jam = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      rem       <= '0;
      coin10    <= 1'b0;
      busy      <= 1'b0;
      eject_5   <= 1'b0;
      eject_10  <= 1'b0;
      done      <= 1'b0;
      short_err <= 1'b0;
      code_err  <= 1'b0;
      cnt_5     <= INV_W'(INIT_5);
      cnt_10    <= INV_W'(INIT_10);
`ifdef CHANGE_DISP_TIMEOUT_EN
      jam       <= 1'b0;
      tmr       <= '0;
`endif
    end else begin
      eject_5   <= 1'b0;
      eject_10  <= 1'b0;
      done      <= 1'b0;
      short_err <= 1'b0;
      code_err  <= 1'b0;
`ifdef CHANGE_DISP_TIMEOUT_EN
      jam       <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (load_5)  cnt_5  <= sat_add(cnt_5, load_qty);
          if (load_10) cnt_10 <= sat_add(cnt_10, load_qty);
          if (req) begin
            if (change >= 3'd5) begin
              code_err <= 1'b1;
            end else if (change != 3'd0) begin
              rem   <= change;
              state <= CHECK;
              busy  <= 1'b1;
            end
          end
        end
        CHECK: begin
          if (short_now) begin
            short_err <= 1'b1;
            rem       <= '0;
            state     <= IDLE;
            busy      <= 1'b0;
          end else begin
            state <= EJECT;
          end
        end
        EJECT: begin
          if (rem >= 3'd2 && cnt_10 != '0) begin
            eject_10 <= 1'b1;
            coin10   <= 1'b1;
          end else begin
            eject_5 <= 1'b1;
            coin10  <= 1'b0;
          end
          state <= WAIT_ACK;
`ifdef CHANGE_DISP_TIMEOUT_EN
          tmr   <= '0;
`endif
        end
        WAIT_ACK: begin
          if (coin_ack) begin
            if (coin10) begin
              cnt_10 <= cnt_10 - 1'b1;
              rem    <= rem - 3'd2;
              state  <= (rem == 3'd2) ? DONE_S : EJECT;
            end else begin
              cnt_5 <= cnt_5 - 1'b1;
              rem   <= rem - 3'd1;
              state <= (rem == 3'd1) ? DONE_S : EJECT;
            end
          end
`ifdef CHANGE_DISP_TIMEOUT_EN
          else if (tmr == TMR_W'(TIMEOUT - 1)) begin
            jam   <= 1'b1;
            rem   <= '0;
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            tmr <= tmr + 1'b1;
          end
`endif
        end
        DONE_S: begin
          done  <= 1'b1;
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
